// File: rtl/nanorv32_ahb_arbiter.sv
// nanorv32_ahb_arbiter: I/D master to single AHB-lite slave arbiter.
// D has priority; a starvation counter bounds I-side wait.
module nanorv32_ahb_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        htransi,
   input  logic [31:0] haddri,
   input  logic [3:0]  hproti,
   input  logic [2:0]  hsizei,
   output logic        hreadyi,
   output logic        hrespi,
   input  logic        htransd,
   input  logic [31:0] haddrd,
   input  logic [3:0]  hprotd,
   input  logic [2:0]  hsized,
   input  logic        hwrited,
   input  logic [31:0] hwdatad,
   output logic        hreadyd,
   output logic        hrespd,
   output logic [31:0] hrdata,
   output logic        htrans_s,
   output logic [31:0] haddr_s,
   output logic [3:0]  hprot_s,
   output logic [2:0]  hsize_s,
   output logic        hwrite_s,
   output logic [31:0] hwdata_s,
   input  logic [31:0] hrdata_s,
   input  logic        hready_s,
   input  logic        hresp_s
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

   logic          pend_v_i_q, pend_v_i_d;
   logic [31:0]   pa_i_q, pa_i_d;
   logic [3:0]    pp_i_q, pp_i_d;
   logic [2:0]    ps_i_q, ps_i_d;
   logic          pend_v_d_q, pend_v_d_d;
   logic [31:0]   pa_d_q, pa_d_d;
   logic [3:0]    pp_d_q, pp_d_d;
   logic [2:0]    ps_d_q, ps_d_d;
   logic          pw_d_q, pw_d_d;
   logic          out_i_q, out_i_d;
   logic          out_d_q, out_d_d;
   logic          dph_v_q, dph_v_d;
   logic          dph_own_q, dph_own_d;
   logic [SW-1:0] starve_q, starve_d;

   logic done_i, done_d;
   logic dreq_i, dreq_d;
   logic req_i, req_d;
   logic win_i, win_d;
   logic issue;

   // dph_own: 1 = D-side, 0 = I-side
   always_comb begin
      done_i   = dph_v_q & ~dph_own_q & hready_s;
      done_d   = dph_v_q & dph_own_q & hready_s;
      hreadyi  = out_i_q ? done_i : 1'b1;
      hreadyd  = out_d_q ? done_d : 1'b1;
      dreq_i   = ~rst & htransi & hreadyi;
      dreq_d   = ~rst & htransd & hreadyd;
      req_i    = ~rst & (pend_v_i_q | dreq_i);
      req_d    = ~rst & (pend_v_d_q | dreq_d);
      win_d    = req_d & ~(req_i & (starve_q == SLIM));
      win_i    = req_i & ~win_d;
      issue    = (win_i | win_d) & hready_s;

      htrans_s = win_i | win_d;
      haddr_s  = '0;
      hprot_s  = '0;
      hsize_s  = '0;
      hwrite_s = 1'b0;
      if (win_d) begin
         haddr_s  = pend_v_d_q ? pa_d_q : haddrd;
         hprot_s  = pend_v_d_q ? pp_d_q : hprotd;
         hsize_s  = pend_v_d_q ? ps_d_q : hsized;
         hwrite_s = pend_v_d_q ? pw_d_q : hwrited;
      end else if (win_i) begin
         haddr_s  = pend_v_i_q ? pa_i_q : haddri;
         hprot_s  = pend_v_i_q ? pp_i_q : hproti;
         hsize_s  = pend_v_i_q ? ps_i_q : hsizei;
      end

      hwdata_s = (dph_v_q & dph_own_q) ? hwdatad : '0;
      hrespi   = dph_v_q & ~dph_own_q & hresp_s;
      hrespd   = dph_v_q & dph_own_q & hresp_s;
      hrdata   = hrdata_s;
   end

   always_comb begin
      pend_v_i_d = pend_v_i_q;
      pa_i_d     = pa_i_q;
      pp_i_d     = pp_i_q;
      ps_i_d     = ps_i_q;
      pend_v_d_d = pend_v_d_q;
      pa_d_d     = pa_d_q;
      pp_d_d     = pp_d_q;
      ps_d_d     = ps_d_q;
      pw_d_d     = pw_d_q;
      dph_v_d    = dph_v_q;
      dph_own_d  = dph_own_q;
      starve_d   = starve_q;

      // an accepted address that loses arbitration parks in pend
      if (issue & win_i) begin
         pend_v_i_d = 1'b0;
      end else if (dreq_i) begin
         pend_v_i_d = 1'b1;
         pa_i_d     = haddri;
         pp_i_d     = hproti;
         ps_i_d     = hsizei;
      end

      if (issue & win_d) begin
         pend_v_d_d = 1'b0;
      end else if (dreq_d) begin
         pend_v_d_d = 1'b1;
         pa_d_d     = haddrd;
         pp_d_d     = hprotd;
         ps_d_d     = hsized;
         pw_d_d     = hwrited;
      end

      out_i_d = dreq_i | (out_i_q & ~done_i);
      out_d_d = dreq_d | (out_d_q & ~done_d);

      if (issue) begin
         dph_v_d   = 1'b1;
         dph_own_d = win_d;
      end else if (hready_s) begin
         dph_v_d   = 1'b0;
      end

      if (issue) begin
         if (win_i) begin
            starve_d = '0;
         end else if (req_i && starve_q != SLIM) begin
            starve_d = starve_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_v_i_q <= 1'b0;
         pa_i_q     <= '0;
         pp_i_q     <= '0;
         ps_i_q     <= '0;
         pend_v_d_q <= 1'b0;
         pa_d_q     <= '0;
         pp_d_q     <= '0;
         ps_d_q     <= '0;
         pw_d_q     <= 1'b0;
         out_i_q    <= 1'b0;
         out_d_q    <= 1'b0;
         dph_v_q    <= 1'b0;
         dph_own_q  <= 1'b0;
         starve_q   <= '0;
      end else begin
         pend_v_i_q <= pend_v_i_d;
         pa_i_q     <= pa_i_d;
         pp_i_q     <= pp_i_d;
         ps_i_q     <= ps_i_d;
         pend_v_d_q <= pend_v_d_d;
         pa_d_q     <= pa_d_d;
         pp_d_q     <= pp_d_d;
         ps_d_q     <= ps_d_d;
         pw_d_q     <= pw_d_d;
         out_i_q    <= out_i_d;
         out_d_q    <= out_d_d;
         dph_v_q    <= dph_v_d;
         dph_own_q  <= dph_own_d;
         starve_q   <= starve_d;
      end
   end

endmodule

// File: tb/tb_nanorv32_ahb_arbiter.sv
// tb_nanorv32_ahb_arbiter: directed stimulus for the I/D AHB arbiter,
// checked against a transaction-level model every cycle.
`timescale 1ns/1ps
module tb_nanorv32_ahb_arbiter;

   localparam int LIM = 4;
   localparam int S_IDLE = 0;
   localparam int S_WAIT = 1;
   localparam int S_DATA = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        htransi;
   logic [31:0] haddri;
   logic [3:0]  hproti;
   logic [2:0]  hsizei;
   logic        hreadyi;
   logic        hrespi;
   logic        htransd;
   logic [31:0] haddrd;
   logic [3:0]  hprotd;
   logic [2:0]  hsized;
   logic        hwrited;
   logic [31:0] hwdatad;
   logic        hreadyd;
   logic        hrespd;
   logic [31:0] hrdata;
   logic        htrans_s;
   logic [31:0] haddr_s;
   logic [3:0]  hprot_s;
   logic [2:0]  hsize_s;
   logic        hwrite_s;
   logic [31:0] hwdata_s;
   logic [31:0] hrdata_s;
   logic        hready_s;
   logic        hresp_s;

   nanorv32_ahb_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .htransi(htransi), .haddri(haddri), .hproti(hproti),
      .hsizei(hsizei), .hreadyi(hreadyi), .hrespi(hrespi),
      .htransd(htransd), .haddrd(haddrd), .hprotd(hprotd),
      .hsized(hsized), .hwrited(hwrited), .hwdatad(hwdatad),
      .hreadyd(hreadyd), .hrespd(hrespd), .hrdata(hrdata),
      .htrans_s(htrans_s), .haddr_s(haddr_s), .hprot_s(hprot_s),
      .hsize_s(hsize_s), .hwrite_s(hwrite_s), .hwdata_s(hwdata_s),
      .hrdata_s(hrdata_s), .hready_s(hready_s), .hresp_s(hresp_s)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] rd_fn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   typedef struct {
      logic [31:0] a;
      logic        w;
      logic [31:0] d;
      logic [2:0]  sz;
   } dtr_t;

   logic [31:0] qi[$];
   dtr_t        qd[$];
   logic        hs_q[$];
   logic [31:0] log_q[$];
   logic [31:0] cur_wd;
   bit          chk_on = 0;

   // model: each master is idle, waiting for the bus, or in its data phase
   int          st [2];
   logic [31:0] ma [2];
   logic [3:0]  mp [2];
   logic [2:0]  ms [2];
   logic        mw [2];
   int          starve_m;

   initial begin
      st[0] = S_IDLE;
      st[1] = S_IDLE;
      starve_m = 0;
   end

   always @(negedge clk) begin : model
      logic        tr [2];
      logic [31:0] pa [2];
      logic [3:0]  pp [2];
      logic [2:0]  ps [2];
      logic        pw [2];
      logic        rdy [2];
      logic        nw [2];
      logic        has [2];
      logic [31:0] ca [2];
      logic [3:0]  cp [2];
      logic [2:0]  cs [2];
      logic        cw [2];
      logic [31:0] e_a;
      logic [3:0]  e_p;
      logic [2:0]  e_s;
      logic        e_w;
      int          pick;
      tr[0] = htransi; pa[0] = haddri; pp[0] = hproti;
      ps[0] = hsizei;  pw[0] = 1'b0;
      tr[1] = htransd; pa[1] = haddrd; pp[1] = hprotd;
      ps[1] = hsized;  pw[1] = hwrited;
      for (int m = 0; m < 2; m++) begin
         if (st[m] == S_WAIT) rdy[m] = 1'b0;
         else if (st[m] == S_DATA) rdy[m] = hready_s;
         else rdy[m] = 1'b1;
         nw[m]  = !rst && tr[m] && rdy[m];
         has[m] = !rst && (st[m] == S_WAIT || nw[m]);
         ca[m]  = (st[m] == S_WAIT) ? ma[m] : pa[m];
         cp[m]  = (st[m] == S_WAIT) ? mp[m] : pp[m];
         cs[m]  = (st[m] == S_WAIT) ? ms[m] : ps[m];
         cw[m]  = (st[m] == S_WAIT) ? mw[m] : pw[m];
      end
      pick = -1;
      if (has[1] && !(has[0] && starve_m == LIM)) pick = 1;
      else if (has[0]) pick = 0;
      e_a = '0; e_p = '0; e_s = '0; e_w = 1'b0;
      if (pick >= 0) begin
         e_a = ca[pick]; e_p = cp[pick]; e_s = cs[pick]; e_w = cw[pick];
      end
      if (chk_on) begin
         chk("hreadyi", 32'(hreadyi), 32'(rdy[0]));
         chk("hreadyd", 32'(hreadyd), 32'(rdy[1]));
         chk("htrans_s", 32'(htrans_s), 32'(pick >= 0));
         chk("haddr_s", haddr_s, e_a);
         chk("hprot_s", 32'(hprot_s), 32'(e_p));
         chk("hsize_s", 32'(hsize_s), 32'(e_s));
         chk("hwrite_s", 32'(hwrite_s), 32'(e_w));
         chk("hwdata_s", hwdata_s, (st[1] == S_DATA) ? hwdatad : 32'h0);
         chk("hrespi", 32'(hrespi),
             32'((st[0] == S_DATA) ? hresp_s : 1'b0));
         chk("hrespd", 32'(hrespd),
             32'((st[1] == S_DATA) ? hresp_s : 1'b0));
         for (int m = 0; m < 2; m++)
            if (st[m] == S_DATA && hready_s && !mw[m])
               chk("hrdata", hrdata, rd_fn(ma[m]));
      end
      if (rst) begin
         st[0] = S_IDLE;
         st[1] = S_IDLE;
         starve_m = 0;
      end else begin
         for (int m = 0; m < 2; m++) begin
            if (st[m] == S_DATA && hready_s) st[m] = S_IDLE;
            if (nw[m]) begin
               st[m] = S_WAIT;
               ma[m] = pa[m]; mp[m] = pp[m]; ms[m] = ps[m]; mw[m] = pw[m];
            end
         end
         if (pick >= 0 && hready_s) begin
            st[pick] = S_DATA;
            ma[pick] = ca[pick]; mp[pick] = cp[pick];
            ms[pick] = cs[pick]; mw[pick] = cw[pick];
            if (pick == 0) starve_m = 0;
            else if (has[0] && starve_m < LIM) starve_m++;
         end
      end
   end

   logic        sn_htrans, sn_ri, sn_rd, sn_pi, sn_pd, sn_hs;
   logic [31:0] sn_haddr, sn_hwdata;

   task automatic drive();
      htransi = qi.size() > 0;
      haddri  = htransi ? qi[0] : 32'h0;
      hproti  = haddri[7:4];
      hsizei  = 3'd2;
      htransd = qd.size() > 0;
      haddrd  = htransd ? qd[0].a : 32'h0;
      hwrited = htransd ? qd[0].w : 1'b0;
      hsized  = htransd ? qd[0].sz : 3'd0;
      hprotd  = haddrd[7:4] ^ 4'h5;
      hwdatad = cur_wd;
      hready_s = (hs_q.size() > 0) ? hs_q.pop_front() : 1'b1;
   endtask

   task automatic tick();
      logic ai, ad, is;
      logic [31:0] ia;
      @(negedge clk);
      ai = !rst && htransi && hreadyi;
      ad = !rst && htransd && hreadyd;
      is = htrans_s && hready_s;
      ia = haddr_s;
      if (is) log_q.push_back(ia);
      sn_htrans = htrans_s; sn_haddr = haddr_s; sn_hwdata = hwdata_s;
      sn_ri = hreadyi; sn_rd = hreadyd; sn_pi = hrespi; sn_pd = hrespd;
      sn_hs = hready_s;
      @(posedge clk);
      #1;
      if (ai && qi.size() > 0) void'(qi.pop_front());
      if (ad && qd.size() > 0) begin
         cur_wd = qd[0].d;
         void'(qd.pop_front());
      end
      if (is) hrdata_s = rd_fn(ia);
      drive();
   endtask

   task automatic chk_log(input string nm, input logic [31:0] exp [$]);
      chk({nm, "_n"}, 32'(log_q.size()), 32'(exp.size()));
      for (int k = 0; k < exp.size() && k < log_q.size(); k++)
         chk(nm, log_q[k], exp[k]);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lo_i, lo_d, held;
      logic [31:0] wd1;
      logic [31:0] exp_q[$];
      rst = 1'b1;
      hresp_s = 1'b0;
      hrdata_s = '0;
      cur_wd = '0;
      drive();
      tick();
      chk_on = 1;
      tick();
      chk("rst_htrans", 32'(sn_htrans), 32'd0);
      chk("rst_hreadyi", 32'(sn_ri), 32'd1);
      chk("rst_hreadyd", 32'(sn_rd), 32'd1);
      chk("rst_hrespi", 32'(sn_pi), 32'd0);
      chk("rst_hrespd", 32'(sn_pd), 32'd0);
      rst = 1'b0;

      // I-only back-to-back
      log_q.delete();
      qi = '{32'h0, 32'h4, 32'h8};
      drive();
      lo_i = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (!sn_ri) lo_i++;
      end
      exp_q = '{32'h0, 32'h4, 32'h8};
      chk_log("ionly_order", exp_q);
      chk("ionly_ready_low", 32'(lo_i), 32'd0);

      // simultaneous I read and D write
      log_q.delete();
      qi = '{32'h100};
      qd.push_back('{a: 32'h2000, w: 1'b1, d: 32'hDEADBEEF, sz: 3'd2});
      drive();
      lo_i = 0;
      wd1 = '0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (!sn_ri) lo_i++;
         if (k == 1) wd1 = sn_hwdata;
      end
      exp_q = '{32'h2000, 32'h100};
      chk_log("both_order", exp_q);
      chk("both_hwdata", wd1, 32'hDEADBEEF);
      chk("both_ready_low", 32'(lo_i), 32'd1);

      // continuous contention: starvation bound
      log_q.delete();
      qi = '{32'h100, 32'h104};
      for (int k = 0; k < 8; k++)
         qd.push_back('{a: 32'h3000 + 32'(4 * k), w: 1'b0, d: 32'h0, sz: 3'd2});
      drive();
      repeat (14) tick();
      exp_q = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h100,
                32'h3010, 32'h3014, 32'h3018, 32'h301C, 32'h104};
      chk_log("starve_order", exp_q);
      chk("starve_qi_empty", 32'(qi.size()), 32'd0);
      chk("starve_qd_empty", 32'(qd.size()), 32'd0);

      // D read with three slave wait states while I is pending
      log_q.delete();
      qi = '{32'h140};
      qd.push_back('{a: 32'h2100, w: 1'b0, d: 32'h0, sz: 3'd2});
      hs_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      drive();
      lo_d = 0;
      held = 0;
      for (int k = 0; k < 7; k++) begin
         tick();
         if (!sn_rd) lo_d++;
         if (sn_htrans && !sn_hs && sn_haddr == 32'h140) held++;
      end
      exp_q = '{32'h2100, 32'h140};
      chk_log("wait_order", exp_q);
      chk("wait_readyd_low", 32'(lo_d), 32'd3);
      chk("wait_i_held", 32'(held), 32'd3);

      // error response in D's data phase
      qd.push_back('{a: 32'h2200, w: 1'b0, d: 32'h0, sz: 3'd2});
      drive();
      tick();
      hresp_s = 1'b1;
      tick();
      chk("resp_hrespd", 32'(sn_pd), 32'd1);
      chk("resp_hrespi", 32'(sn_pi), 32'd0);
      hresp_s = 1'b0;
      tick();

      // reset in the middle of a transfer with I pending
      qi = '{32'h180};
      qd.push_back('{a: 32'h2300, w: 1'b0, d: 32'h0, sz: 3'd2});
      drive();
      tick();
      rst = 1'b1;
      qi.delete();
      qd.delete();
      drive();
      tick();
      chk("midrst_htrans", 32'(sn_htrans), 32'd0);
      rst = 1'b0;
      hresp_s = 1'b1;
      tick();
      chk("post_rst_htrans", 32'(sn_htrans), 32'd0);
      chk("post_rst_hreadyi", 32'(sn_ri), 32'd1);
      chk("post_rst_hreadyd", 32'(sn_rd), 32'd1);
      chk("post_rst_hrespi", 32'(sn_pi), 32'd0);
      chk("post_rst_hrespd", 32'(sn_pd), 32'd0);
      hresp_s = 1'b0;

      // I alone after reset: starve and pend state start clean
      log_q.delete();
      qi = '{32'h1C0};
      drive();
      repeat (3) tick();
      exp_q = '{32'h1C0};
      chk_log("post_rst_order", exp_q);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
